jt12_timers: RTL
================

# jt12_timers

Timer A / Timer B block of the FM core. Counts sample-rate ticks, raises the status flags and the IRQ line, and produces the `overflow_A` strobe that the key-on stage uses for CSM key-on of channel 3. Sits between the register file (value/load/enable/reset-flag fields of registers 0x24–0x27) and the key-on and status-read logic.

## Interface
Parameters:
- `SLOTS`, 24: clk_en cycles per sample; length of the `overflow_A` hold window.
- `TB_PRESCALE`, 16: zero ticks per Timer B count.

Ports:
- `clk` in 1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_en` in 1: qualifies every state update. No state changes when low.
- `zero` in 1: start-of-sample tick, high for one clk_en cycle every `SLOTS` clk_en cycles.
- `value_A` in 10: Timer A reload value (NA).
- `value_B` in 8: Timer B reload value (NB).
- `load_A`, `load_B` in 1: timer run bits (reg 0x27 bits 0/1).
- `en_irq_A`, `en_irq_B` in 1: flag enable bits (reg 0x27 bits 2/3).
- `clr_flag_A`, `clr_flag_B` in 1: flag reset strobes (reg 0x27 bits 4/5), one clk_en cycle.
- `flag_A`, `flag_B` out 1: status flags.
- `overflow_A` out 1: CSM strobe; high for one full sample window after a Timer A overflow.
- `irq_n` out 1: active-low interrupt, `~(flag_A | flag_B)`, registered.

## Operation
- Timer A: 10-bit up-counter `cnt_A`, advances by 1 on each clk_en cycle with `zero=1` and `load_A=1`.
- Timer B: 4-bit prescaler counts `zero` ticks while `load_B=1`; `cnt_B` (8-bit) advances when the prescaler wraps 15→0.
- Load: on a rising edge of `load_X` (sampled on clk_en), `cnt_X ← value_X`, and for B the prescaler ← 0. While `load_X=0`, counter and prescaler hold; no overflow, no flag set.
- Overflow: a count step from all-ones (1023 / 255) reloads `cnt_X ← value_X` in the same cycle, with no dead count. Period A = (1024−NA) samples; period B = 16·(256−NB) samples.
- Flag set: on overflow when `en_irq_X=1`. Flag clear: `clr_flag_X=1`. Set and clear in the same cycle → flag set. Disabling `en_irq_X` does not clear an already set flag.
- `overflow_A`: set on every Timer A overflow, regardless of `en_irq_A`. Cleared on the next clk_en cycle with `zero=1` that is not itself an overflow step. Each overflow therefore yields exactly `SLOTS` clk_en cycles high, covering every channel-3 operator slot once.
- NA=1023 or NB=255: overflow on every step, and the flag re-sets each step.

## Timing
- Reset values: `cnt_A=0`, `cnt_B=0`, prescaler 0, `flag_A=0`, `flag_B=0`, `overflow_A=0`, `irq_n=1`, load edge detectors 0.
- Overflow step at clk_en cycle n: `flag_X` and `overflow_A` are high from cycle n+1. `irq_n` goes low at n+2 (registered from the flags).
- Load edge at cycle n: counter holds `value_X` at n+1. A `zero` coinciding with the load edge does not count.
- `rst_n` asserted mid-count or mid-window: all state returns to reset values immediately. After release, counters idle until a fresh `load_X` rising edge.

## Configuration
- `JT12_CSM_EN` defined: `overflow_A` behaves as above.
- `JT12_CSM_EN` undefined: `overflow_A` is tied to 0 and its window logic is removed. Flags and IRQ are unchanged.

## Structure
- `jt12_timers_pkg`:
  - `TA_W=10`, `TB_W=8`, `PRESC_W=4`.
  - Default `SLOTS` and `TB_PRESCALE`.
  - Typedef `timer_ctl_t` {load, en_irq, clr_flag}.
- Sub-module `jt12_timer_cnt`, parameterised by counter width and prescale, instantiated once per timer (prescale 1 for A). It contains the load-edge detector, counter, reload and flag logic. The top level adds the `overflow_A` window and `irq_n`.

## Test plan
- NA=1020, `load_A`↑, `en_irq_A=1` → overflow after 4 zero ticks; `flag_A`=1 one clk_en later; `irq_n`=0 the cycle after; repeats every 4 ticks.
- NB=254, `load_B`↑ → `flag_B` sets after 32 zero ticks; `clr_flag_B` pulse → `flag_B`=0, `irq_n`=1 next cycle.
- NA=1023, `en_irq_A=0` with `JT12_CSM_EN` → `overflow_A` high exactly 24 clk_en cycles per tick; `flag_A` stays 0. Without the macro → `overflow_A` constant 0.
- `clr_flag_A` in the same cycle as a Timer A overflow → `flag_A`=1.
- `load_A` dropped mid-count at `cnt_A`=1000, then raised → counter reloads NA and the period restarts from NA.
- `rst_n` low during an `overflow_A` window → all outputs at reset values immediately; no counting until a new `load` edge.

Source files
------------

// File: rtl/jt12_timers_pkg.sv
// Shared widths, defaults and control bundle for the jt12 Timer A/B block.
package jt12_timers_pkg;

  localparam int TA_W            = 10;
  localparam int TB_W            = 8;
  localparam int PRESC_W         = 4;
  localparam int SLOTS_DEF       = 24;
  localparam int TB_PRESCALE_DEF = 16;

  typedef struct packed {
    logic load;
    logic en_irq;
    logic clr_flag;
  } timer_ctl_t;

endpackage

// File: rtl/jt12_timers_if.sv
// Register-file side bundle of the timer block: reload values, control bits and status outputs.
interface jt12_timers_if;
  import jt12_timers_pkg::*;

  logic [TA_W-1:0] value_A;
  logic [TB_W-1:0] value_B;
  logic            load_A;
  logic            load_B;
  logic            en_irq_A;
  logic            en_irq_B;
  logic            clr_flag_A;
  logic            clr_flag_B;
  logic            flag_A;
  logic            flag_B;
  logic            overflow_A;
  logic            irq_n;

  modport master (
    output value_A, value_B, load_A, load_B, en_irq_A, en_irq_B, clr_flag_A, clr_flag_B,
    input  flag_A, flag_B, overflow_A, irq_n
  );

  modport slave (
    input  value_A, value_B, load_A, load_B, en_irq_A, en_irq_B, clr_flag_A, clr_flag_B,
    output flag_A, flag_B, overflow_A, irq_n
  );

endinterface

// File: rtl/jt12_timer_cnt.sv
// One YM2612 timer: load-edge detector, optional zero-tick prescaler, up-counter with reload, status flag.
module jt12_timer_cnt
  import jt12_timers_pkg::*;
#(
  parameter int CNT_W    = TA_W,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             zero,
  input  logic [CNT_W-1:0] value_i,
  input  timer_ctl_t       ctl_i,
  output logic             ovf_o,
  output logic             flag_o
);

  logic               load_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               flag_q, flag_d;
  logic               load_edge, step, ovf;

  always_comb begin
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    step      = 1'b0;
    ovf       = 1'b0;
    load_edge = ctl_i.load & ~load_q;
    // A zero tick coinciding with the load edge is swallowed by the reload.
    if (load_edge) begin
      cnt_d   = value_i;
      presc_d = '0;
    end else if (ctl_i.load && zero) begin
      if (PRESCALE <= 1) begin
        step = 1'b1;
      end else begin
        step    = (presc_q == PRESC_W'(PRESCALE - 1));
        presc_d = step ? '0 : presc_q + 1'b1;
      end
      if (step) begin
        if (&cnt_q) begin
          cnt_d = value_i;
          ovf   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    // Set wins over a simultaneous clear.
    if (ovf && ctl_i.en_irq) flag_d = 1'b1;
    else if (ctl_i.clr_flag) flag_d = 1'b0;
    else                     flag_d = flag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q  <= 1'b0;
      cnt_q   <= '0;
      presc_q <= '0;
      flag_q  <= 1'b0;
    end else if (clk_en) begin
      load_q  <= ctl_i.load;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      flag_q  <= flag_d;
    end
  end

  assign ovf_o  = clk_en & ovf;
  assign flag_o = flag_q;

endmodule

// File: rtl/jt12_timers.sv
// Timer A/B top: two timer instances, registered IRQ and the CSM overflow_A window.
// Define JT12_CSM_EN to build the overflow_A window; otherwise overflow_A is tied low.
module jt12_timers
  import jt12_timers_pkg::*;
#(
  parameter int SLOTS       = SLOTS_DEF,
  parameter int TB_PRESCALE = TB_PRESCALE_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          zero,
  jt12_timers_if.slave  tif
);

  if (SLOTS < 1 || TB_PRESCALE < 1 || TB_PRESCALE > (1 << PRESC_W)) begin : g_param_check
    $error("jt12_timers: SLOTS/TB_PRESCALE out of range");
  end

  timer_ctl_t ctl_A, ctl_B;
  logic       ovf_A, ovf_B;
  logic       flag_A, flag_B;
  logic       irq_n_q;
  logic       unused_ovf;

  assign ctl_A = '{load: tif.load_A, en_irq: tif.en_irq_A, clr_flag: tif.clr_flag_A};
  assign ctl_B = '{load: tif.load_B, en_irq: tif.en_irq_B, clr_flag: tif.clr_flag_B};

  jt12_timer_cnt #(.CNT_W(TA_W), .PRESCALE(1)) u_timer_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .zero    (zero),
    .value_i (tif.value_A),
    .ctl_i   (ctl_A),
    .ovf_o   (ovf_A),
    .flag_o  (flag_A)
  );

  jt12_timer_cnt #(.CNT_W(TB_W), .PRESCALE(TB_PRESCALE)) u_timer_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .zero    (zero),
    .value_i (tif.value_B),
    .ctl_i   (ctl_B),
    .ovf_o   (ovf_B),
    .flag_o  (flag_B)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      irq_n_q <= 1'b1;
    else if (clk_en) irq_n_q <= ~(flag_A | flag_B);
  end

`ifdef JT12_CSM_EN
  logic ovf_win_q, ovf_win_d;

  // Held from the overflow step until the next plain zero tick: one full sample of slots.
  always_comb begin
    ovf_win_d = ovf_win_q;
    if (ovf_A)     ovf_win_d = 1'b1;
    else if (zero) ovf_win_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf_win_q <= 1'b0;
    else if (clk_en) ovf_win_q <= ovf_win_d;
  end

  assign tif.overflow_A = ovf_win_q;
  assign unused_ovf     = ovf_B;
`else
  assign tif.overflow_A = 1'b0;
  assign unused_ovf     = ovf_A ^ ovf_B;
`endif

  assign tif.flag_A = flag_A;
  assign tif.flag_B = flag_B;
  assign tif.irq_n  = irq_n_q;

endmodule
